// File: rtl/uart_fifo_mon_pkg.sv
// rtl/uart_fifo_mon_pkg.sv - shared constants, width helper and stat record for the FIFO level monitor
package uart_fifo_mon_pkg;

  localparam int CH_TX = 0;
  localparam int CH_RX = 1;

  // Widest level field for the legal DEPTH range (256 needs 9 bits).
  localparam int LVL_MAX_W = 9;

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic [LVL_MAX_W-1:0] level;
    logic [LVL_MAX_W-1:0] hwm;
    logic                 full;
    logic                 empty;
    logic                 ovf;
    logic                 unf;
  } uart_fifo_stat_t;

endpackage

// File: rtl/uart_fifo_level_chan.sv
// rtl/uart_fifo_level_chan.sv - one channel: occupancy, hwm, sticky flags, threshold pulse and counter
module uart_fifo_level_chan
  import uart_fifo_mon_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = lvl_width(DEPTH),
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_stats,
  input  logic [LVL_W-1:0] thr,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] hwm,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf,
  output logic             thr_hit,
  output logic [CNT_W-1:0] thr_cnt
);

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic             pop_ok;
  logic             push_ok;
  logic [LVL_W-1:0] level_next;
  logic             hit_next;

  always_comb begin
    pop_ok     = pop && (level != '0);
    // A push into a full FIFO is only accepted if a pop frees a slot this cycle.
    push_ok    = push && ((level != DEPTH_L) || pop_ok);
    level_next = level + LVL_W'(push_ok) - LVL_W'(pop_ok);
    hit_next   = (level < thr) && (level_next >= thr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level   <= '0;
      hwm     <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      thr_hit <= 1'b0;
      thr_cnt <= '0;
    end else begin
      level   <= level_next;
      full    <= (level_next == DEPTH_L);
      empty   <= (level_next == '0);
      thr_hit <= hit_next;
      if (clr_stats) begin
        hwm     <= level_next;
        ovf     <= 1'b0;
        unf     <= 1'b0;
        thr_cnt <= '0;
      end else begin
        if (level_next > hwm) hwm <= level_next;
        if (push && !push_ok) ovf <= 1'b1;
        if (pop && !pop_ok) unf <= 1'b1;
        if (hit_next && (thr_cnt != '1)) thr_cnt <= thr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_level_monitor.sv
// rtl/uart_fifo_level_monitor.sv - NUM_CH independent FIFO level monitors with packed outputs
module uart_fifo_level_monitor
  import uart_fifo_mon_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = lvl_width(DEPTH),
  parameter int CNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       push,
  input  logic [NUM_CH-1:0]       pop,
  input  logic [NUM_CH-1:0]       clr_stats,
  input  logic [NUM_CH*LVL_W-1:0] thr,
  output logic [NUM_CH*LVL_W-1:0] level,
  output logic [NUM_CH*LVL_W-1:0] hwm,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       unf,
  output logic [NUM_CH-1:0]       thr_hit,
  output logic [NUM_CH*CNT_W-1:0] thr_cnt
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    uart_fifo_level_chan #(
      .DEPTH(DEPTH),
      .LVL_W(LVL_W),
      .CNT_W(CNT_W)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .push     (push[i]),
      .pop      (pop[i]),
      .clr_stats(clr_stats[i]),
      .thr      (thr[i*LVL_W +: LVL_W]),
      .level    (level[i*LVL_W +: LVL_W]),
      .hwm      (hwm[i*LVL_W +: LVL_W]),
      .full     (full[i]),
      .empty    (empty[i]),
      .ovf      (ovf[i]),
      .unf      (unf[i]),
      .thr_hit  (thr_hit[i]),
      .thr_cnt  (thr_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_uart_fifo_level_monitor.sv
// tb/tb_uart_fifo_level_monitor.sv - scoreboard bench for the FIFO level monitor
module tb_uart_fifo_level_monitor;
  import uart_fifo_mon_pkg::*;

  localparam int NUM_CH  = 2;
  localparam int DEPTH   = 16;
  localparam int LVL_W   = lvl_width(DEPTH);
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic                    clock;
  logic                    reset;
  logic [NUM_CH-1:0]       push;
  logic [NUM_CH-1:0]       pop;
  logic [NUM_CH-1:0]       clr_stats;
  logic [NUM_CH*LVL_W-1:0] thr;
  logic [NUM_CH*LVL_W-1:0] level;
  logic [NUM_CH*LVL_W-1:0] hwm;
  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       empty;
  logic [NUM_CH-1:0]       ovf;
  logic [NUM_CH-1:0]       unf;
  logic [NUM_CH-1:0]       thr_hit;
  logic [NUM_CH*CNT_W-1:0] thr_cnt;

  uart_fifo_level_monitor #(
    .NUM_CH(NUM_CH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clr_stats(clr_stats),
    .thr      (thr),
    .level    (level),
    .hwm      (hwm),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .unf      (unf),
    .thr_hit  (thr_hit),
    .thr_cnt  (thr_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    uart_fifo_stat_t st;
    logic            hit;
    int              cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_level[NUM_CH];
  int   m_hwm[NUM_CH];
  bit   m_ovf[NUM_CH];
  bit   m_unf[NUM_CH];
  int   m_cnt[NUM_CH];
  int   hit_seen[NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lv(input int ch);
    return int'(level[ch*LVL_W +: LVL_W]);
  endfunction

  function automatic int hv(input int ch);
    return int'(hwm[ch*LVL_W +: LVL_W]);
  endfunction

  function automatic int cv(input int ch);
    return int'(thr_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  function automatic void set_thr(input int ch, input int t);
    thr[ch*LVL_W +: LVL_W] = LVL_W'(t);
  endfunction

  // Reference model: pushes the expected post-edge state of every channel.
  task automatic model_step();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp_t e;
      int   l, nl, t;
      bit   o, u, h;
      h = 1'b0;
      if (reset) begin
        m_level[ch] = 0; m_hwm[ch] = 0; m_ovf[ch] = 0; m_unf[ch] = 0; m_cnt[ch] = 0;
      end else begin
        l  = m_level[ch];
        nl = l;
        o  = 1'b0;
        u  = 1'b0;
        t  = int'(thr[ch*LVL_W +: LVL_W]);
        if (pop[ch]) begin
          if (l == 0) u = 1'b1;
          else nl = nl - 1;
        end
        if (push[ch]) begin
          if (nl < DEPTH) nl = nl + 1;
          else o = 1'b1;
        end
        h = (l < t) && (nl >= t);
        if (clr_stats[ch]) begin
          m_ovf[ch] = 0; m_unf[ch] = 0; m_cnt[ch] = 0; m_hwm[ch] = nl;
        end else begin
          m_ovf[ch] = m_ovf[ch] | o;
          m_unf[ch] = m_unf[ch] | u;
          if (h && m_cnt[ch] < CNT_MAX) m_cnt[ch] = m_cnt[ch] + 1;
          if (nl > m_hwm[ch]) m_hwm[ch] = nl;
        end
        m_level[ch] = nl;
      end
      e.st.level = LVL_MAX_W'(m_level[ch]);
      e.st.hwm   = LVL_MAX_W'(m_hwm[ch]);
      e.st.full  = (m_level[ch] == DEPTH);
      e.st.empty = (m_level[ch] == 0);
      e.st.ovf   = m_ovf[ch];
      e.st.unf   = m_unf[ch];
      e.hit      = h;
      e.cnt      = m_cnt[ch];
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("ch%0d_level", ch), lv(ch), e.st.level);
      check($sformatf("ch%0d_hwm", ch), hv(ch), e.st.hwm);
      check($sformatf("ch%0d_full", ch), full[ch], e.st.full);
      check($sformatf("ch%0d_empty", ch), empty[ch], e.st.empty);
      check($sformatf("ch%0d_ovf", ch), ovf[ch], e.st.ovf);
      check($sformatf("ch%0d_unf", ch), unf[ch], e.st.unf);
      check($sformatf("ch%0d_thr_hit", ch), thr_hit[ch], e.hit);
      check($sformatf("ch%0d_thr_cnt", ch), cv(ch), e.cnt);
      if (thr_hit[ch] === 1'b1) hit_seen[ch]++;
    end
  endtask

  task automatic drive(input int ch, input bit pu, input bit po, input int n);
    for (int i = 0; i < n; i++) begin
      push = '0; pop = '0;
      push[ch] = pu;
      pop[ch]  = po;
      tick();
    end
    push = '0; pop = '0;
  endtask

  initial begin
    reset = 1'b1; push = '0; pop = '0; clr_stats = '0; thr = '0;
    hit_seen = '{default: 0};
    tick();
    tick();
    reset = 1'b0;
    check("rst_level", level, 0);
    check("rst_empty", empty, 2'b11);
    check("rst_cnt", thr_cnt, 0);

    drive(CH_TX, 1, 0, 16);
    check("fill_level", lv(CH_TX), 16);
    check("fill_full", full[CH_TX], 1);
    check("fill_hwm", hv(CH_TX), 16);
    check("fill_ovf", ovf[CH_TX], 0);
    drive(CH_TX, 1, 0, 1);
    check("over_ovf", ovf[CH_TX], 1);
    check("over_level", lv(CH_TX), 16);

    drive(CH_RX, 1, 1, 1);
    check("rx_unf", unf[CH_RX], 1);
    check("rx_level", lv(CH_RX), 1);
    check("rx_empty", empty[CH_RX], 0);

    clr_stats = 2'b01;
    tick();
    clr_stats = '0;
    check("clr_ovf", ovf[CH_TX], 0);
    check("clr_hwm", hv(CH_TX), 16);
    for (int i = 0; i < 5; i++) begin
      drive(CH_TX, 1, 1, 1);
      check("fullpp_level", lv(CH_TX), 16);
      check("fullpp_ovf", ovf[CH_TX], 0);
    end

    drive(CH_TX, 0, 1, 16);
    clr_stats = 2'b01;
    tick();
    clr_stats = '0;
    set_thr(CH_TX, 8);
    hit_seen[CH_TX] = 0;
    drive(CH_TX, 1, 0, 10);
    drive(CH_TX, 0, 1, 5);
    drive(CH_TX, 1, 0, 3);
    check("thr_pulses", hit_seen[CH_TX], 2);
    check("thr_cnt2", cv(CH_TX), 2);
    set_thr(CH_TX, 4);
    tick();
    check("thr_change_nohit", thr_hit[CH_TX], 0);
    set_thr(CH_TX, 8);
    tick();
    check("thr_restore_nohit", thr_hit[CH_TX], 0);

    for (int i = 0; i < 20; i++) begin
      drive(CH_TX, 0, 1, 1);
      drive(CH_TX, 1, 0, 1);
    end
    check("sat_cnt", cv(CH_TX), CNT_MAX);
    drive(CH_TX, 0, 1, 1);
    push[CH_TX] = 1'b1;
    clr_stats = 2'b01;
    tick();
    push = '0; clr_stats = '0;
    check("clr_hit_pulse", thr_hit[CH_TX], 1);
    check("clr_hit_cnt", cv(CH_TX), 0);

    set_thr(CH_TX, 20);
    hit_seen[CH_TX] = 0;
    drive(CH_TX, 1, 0, 8);
    check("thr_above_depth", hit_seen[CH_TX], 0);
    set_thr(CH_TX, 0);
    drive(CH_TX, 0, 1, 16);
    drive(CH_TX, 1, 0, 7);
    check("midfill_level", lv(CH_TX), 7);
    check("rx_isolated", lv(CH_RX), 1);
    push[CH_TX] = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; push = '0;
    check("midrst_level", lv(CH_TX), 0);
    check("midrst_hwm", hv(CH_TX), 0);
    check("midrst_flags", {full[CH_TX], ovf[CH_TX], unf[CH_TX], thr_hit[CH_TX]}, 0);
    check("midrst_empty", empty[CH_TX], 1);

    for (int i = 0; i < 400; i++) begin
      push      = NUM_CH'($urandom);
      pop       = NUM_CH'($urandom);
      clr_stats = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
      if ($urandom_range(0, 7) == 0) thr = (NUM_CH*LVL_W)'($urandom);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; push = '0; pop = '0; clr_stats = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_level_monitor.md
Name: uart_fifo_level_monitor

Overview:
- Parametrised white-box monitor for UART controller FIFOs. Tracks occupancy of NUM_CH FIFOs from their push/pop strobes.
- Generalises the fixed tx/rx pointer pair to N channels of configurable depth.
- Adds high-water marks, sticky overflow/underflow flags, threshold-crossing pulses and saturating crossing counters for coverage and assertions.
- Sits beside the UART controller in the coverage/bench layer, driven by probed FIFO strobes.

Parameters:
- NUM_CH, 2, number of monitored FIFOs (channel 0 = TX, channel 1 = RX by convention).
- DEPTH, 16, FIFO capacity in entries; legal range 2..256.
- LVL_W, $clog2(DEPTH+1), width of level fields (derived; do not override).
- CNT_W, 16, width of crossing counters.

Ports:
- clock  in  1  sole clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- push  in  NUM_CH  per-channel write strobe.
- pop  in  NUM_CH  per-channel read strobe.
- clr_stats  in  NUM_CH  per-channel stats clear (hwm, flags, counter); level untouched.
- thr  in  NUM_CH*LVL_W  per-channel threshold, sampled each cycle.
- level  out  NUM_CH*LVL_W  current occupancy.
- hwm  out  NUM_CH*LVL_W  maximum level since reset/clear.
- full  out  NUM_CH  level==DEPTH.
- empty  out  NUM_CH  level==0.
- ovf  out  NUM_CH  sticky: push rejected while full.
- unf  out  NUM_CH  sticky: pop while empty.
- thr_hit  out  NUM_CH  one-cycle pulse on upward threshold crossing.
- thr_cnt  out  NUM_CH*CNT_W  saturating count of thr_hit pulses.

Behaviour:
- Reset (reset=1 at an edge): level=0, hwm=0, empty=1, full=0, ovf=0, unf=0, thr_hit=0, thr_cnt=0, for all channels. Reset overrides all other inputs in that cycle.
- Channels are fully independent; there is no cross-channel interaction.
- All outputs are registered; an event at edge k is visible after edge k.
- Level update, applied each cycle:
  - pop is valid when level>0; otherwise unf is set and the pop is ignored.
  - push is valid when level<DEPTH, or when level==DEPTH with a valid pop in the same cycle. Otherwise ovf is set and the push is ignored.
  - level_next = level + valid_push - valid_pop.
  - empty and push and pop together: pop ignored, unf set, level becomes 1.
  - full and push and pop together: level stays DEPTH, no flag set.
- hwm: hwm_next = max(hwm, level_next). Monotonic until clear or reset.
- thr_hit pulses for one cycle when level < thr and level_next >= thr.
  - thr==0 never fires.
  - thr > DEPTH never fires.
  - A change of thr with no level change does not fire.
- thr_cnt increments on each thr_hit and saturates at 2^CNT_W-1, with no wrap.
- clr_stats in a cycle:
  - ovf, unf and thr_cnt go to 0.
  - hwm is set to level_next.
  - An event in the same cycle is lost: the clear has priority over setting ovf/unf and over the counter increment.
  - A thr_hit pulse in the same cycle is still emitted.
- Arithmetic is unsigned. Level never leaves the range 0..DEPTH.

Decomposition:
- Package uart_fifo_mon_pkg:
  - constants CH_TX=0, CH_RX=1.
  - function lvl_width(depth).
  - struct uart_fifo_stat_t {level, hwm, full, empty, ovf, unf}, for bench sampling.
- Sub-module uart_fifo_level_chan: one channel's counter, flags, hwm and thr logic.
- Top generates NUM_CH instances and packs their outputs; it has no logic of its own.

Test Plan:
- Reset, then 16 pushes on ch0 with DEPTH=16 -> level 16, full=1, hwm=16, ovf=0. A 17th push -> ovf=1, level stays 16.
- Pop on empty ch1 simultaneous with push -> unf=1, level=1, empty=0 on the next cycle.
- Full ch0 with push and pop in the same cycle for 5 cycles -> level 16 throughout, no ovf.
- thr=8 on ch0:
  - fill to 10, drain to 5, refill to 8 -> thr_hit pulses twice, thr_cnt=2.
  - Then change thr to 4 with level held -> no pulse.
- CNT_W=4, 20 threshold crossings -> thr_cnt saturates at 15. clr_stats together with a crossing -> thr_cnt=0, thr_hit pulse observed.
- Reset asserted mid-fill at level 7 with push active -> next cycle level=0, hwm=0, all flags 0. Channel 1 state is unaffected by ch0 traffic throughout.
